// File: rtl/nasti_stream_merger_if.sv
// NASTI stream channel: N_CHANNEL parallel AXI-stream style lanes sharing one bundle.
// Senders use the master modport and receivers use the slave modport.
interface nasti_stream_channel #(
   parameter int N_CHANNEL  = 1,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 4
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [N_CHANNEL-1:0]                 t_valid;
   logic [N_CHANNEL-1:0]                 t_ready;
   logic [N_CHANNEL-1:0][DATA_WIDTH-1:0] t_data;
   logic [N_CHANNEL-1:0][STRB_WIDTH-1:0] t_strb;
   logic [N_CHANNEL-1:0][STRB_WIDTH-1:0] t_keep;
   logic [N_CHANNEL-1:0]                 t_last;
   logic [N_CHANNEL-1:0][ID_WIDTH-1:0]   t_id;
   logic [N_CHANNEL-1:0][DEST_WIDTH-1:0] t_dest;
   logic [N_CHANNEL-1:0][USER_WIDTH-1:0] t_user;

   modport master (
      output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
      input  t_ready
   );

   modport slave (
      input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
      output t_ready
   );
endinterface

// File: rtl/nasti_stream_merger.sv
// Packet-atomic round-robin merger of up to eight NASTI streams onto one output lane,
// with a single full-throughput output register stage.
module nasti_stream_merger #(
   parameter int N_PORT     = 1,
   parameter int N_CHANNEL  = 1,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rstn,
   nasti_stream_channel.slave slave_0,
   nasti_stream_channel.slave slave_1,
   nasti_stream_channel.slave slave_2,
   nasti_stream_channel.slave slave_3,
   nasti_stream_channel.slave slave_4,
   nasti_stream_channel.slave slave_5,
   nasti_stream_channel.slave slave_6,
   nasti_stream_channel.slave slave_7,
   nasti_stream_channel.master master
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [7:0] PORT_MASK = 8'((9'd1 << N_PORT) - 9'd1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_WIDTH-1:0] strb;
      logic [STRB_WIDTH-1:0] keep;
      logic                  last;
      logic [ID_WIDTH-1:0]   id;
      logic [DEST_WIDTH-1:0] dest;
      logic [USER_WIDTH-1:0] user;
   } beat_t;

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t     state_q, state_d;
   logic [2:0] lock_q, lock_d;
   logic [2:0] last_q, last_d;
   logic       out_valid_q;
   beat_t      out_beat_q;

   logic [7:0] raw_valid;
   logic [7:0] in_valid;
   logic [7:0] in_ready;
   beat_t      in_beat [8];
   logic [2:0] grant_idx;
   logic [2:0] cand;
   logic       grant_en;
   logic       buf_free;
   logic       accept;

   assign raw_valid = {slave_7.t_valid[0], slave_6.t_valid[0], slave_5.t_valid[0],
                       slave_4.t_valid[0], slave_3.t_valid[0], slave_2.t_valid[0],
                       slave_1.t_valid[0], slave_0.t_valid[0]};
   // Ports at or above N_PORT are masked here so they can never win arbitration.
   assign in_valid  = raw_valid & PORT_MASK;

   assign in_beat[0] = {slave_0.t_data[0], slave_0.t_strb[0], slave_0.t_keep[0], slave_0.t_last[0],
                        slave_0.t_id[0], slave_0.t_dest[0], slave_0.t_user[0]};
   assign in_beat[1] = {slave_1.t_data[0], slave_1.t_strb[0], slave_1.t_keep[0], slave_1.t_last[0],
                        slave_1.t_id[0], slave_1.t_dest[0], slave_1.t_user[0]};
   assign in_beat[2] = {slave_2.t_data[0], slave_2.t_strb[0], slave_2.t_keep[0], slave_2.t_last[0],
                        slave_2.t_id[0], slave_2.t_dest[0], slave_2.t_user[0]};
   assign in_beat[3] = {slave_3.t_data[0], slave_3.t_strb[0], slave_3.t_keep[0], slave_3.t_last[0],
                        slave_3.t_id[0], slave_3.t_dest[0], slave_3.t_user[0]};
   assign in_beat[4] = {slave_4.t_data[0], slave_4.t_strb[0], slave_4.t_keep[0], slave_4.t_last[0],
                        slave_4.t_id[0], slave_4.t_dest[0], slave_4.t_user[0]};
   assign in_beat[5] = {slave_5.t_data[0], slave_5.t_strb[0], slave_5.t_keep[0], slave_5.t_last[0],
                        slave_5.t_id[0], slave_5.t_dest[0], slave_5.t_user[0]};
   assign in_beat[6] = {slave_6.t_data[0], slave_6.t_strb[0], slave_6.t_keep[0], slave_6.t_last[0],
                        slave_6.t_id[0], slave_6.t_dest[0], slave_6.t_user[0]};
   assign in_beat[7] = {slave_7.t_data[0], slave_7.t_strb[0], slave_7.t_keep[0], slave_7.t_last[0],
                        slave_7.t_id[0], slave_7.t_dest[0], slave_7.t_user[0]};

   assign buf_free = !out_valid_q || master.t_ready[0];

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      grant_en  = 1'b0;
      grant_idx = '0;
      cand      = '0;
      in_ready  = '0;
      state_d   = state_q;
      lock_d    = lock_q;
      last_d    = last_q;

      if (state_q == S_LOCKED) begin
         grant_en  = 1'b1;
         grant_idx = lock_q;
      end else begin
         for (int i = 1; i <= N_PORT; i++) begin
            cand = 3'((int'(last_q) + i) % N_PORT);
            if (!grant_en && in_valid[cand]) begin
               grant_en  = 1'b1;
               grant_idx = cand;
            end
         end
      end

      if (rstn && grant_en) in_ready[grant_idx] = buf_free;
      accept = rstn && grant_en && in_valid[grant_idx] && buf_free;

      if (accept) begin
         if (state_q == S_IDLE) begin
            last_d = grant_idx;
            lock_d = grant_idx;
            if (!in_beat[grant_idx].last) state_d = S_LOCKED;
         end else if (in_beat[grant_idx].last) begin
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (!rstn) begin
         state_q     <= S_IDLE;
         lock_q      <= '0;
         last_q      <= 3'(N_PORT - 1);
         out_valid_q <= 1'b0;
         out_beat_q  <= '0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         last_q  <= last_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_beat_q  <= in_beat[grant_idx];
         end else if (master.t_ready[0]) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      master.t_valid = '0;
      master.t_data  = '0;
      master.t_strb  = '0;
      master.t_keep  = '0;
      master.t_last  = '0;
      master.t_id    = '0;
      master.t_dest  = '0;
      master.t_user  = '0;
      master.t_valid[0] = out_valid_q;
      master.t_data[0]  = out_beat_q.data;
      master.t_strb[0]  = out_beat_q.strb;
      master.t_keep[0]  = out_beat_q.keep;
      master.t_last[0]  = out_beat_q.last;
      master.t_id[0]    = out_beat_q.id;
      master.t_dest[0]  = out_beat_q.dest;
      master.t_user[0]  = out_beat_q.user;

      slave_0.t_ready = '0;  slave_0.t_ready[0] = in_ready[0];
      slave_1.t_ready = '0;  slave_1.t_ready[0] = in_ready[1];
      slave_2.t_ready = '0;  slave_2.t_ready[0] = in_ready[2];
      slave_3.t_ready = '0;  slave_3.t_ready[0] = in_ready[3];
      slave_4.t_ready = '0;  slave_4.t_ready[0] = in_ready[4];
      slave_5.t_ready = '0;  slave_5.t_ready[0] = in_ready[5];
      slave_6.t_ready = '0;  slave_6.t_ready[0] = in_ready[6];
      slave_7.t_ready = '0;  slave_7.t_ready[0] = in_ready[7];
   end
endmodule
